endec_tx_serializer: RTL and testbench

ENDEC_TX_SERIALIZER -- requirements
Module: endec_tx_serializer

---
 rtl/endec_tx_serializer.sv | 123 ++++++++++++
 tb/tb_endec_tx_serializer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/endec_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : endec_tx_serializer
//  Description : Captures one encoded frame (256 or 384 valid bits) from the
//                encoder and streams it out LSB word first as OUT_W-bit words
//                over a valid/ready handshake. Back-to-back frames are
//                accepted on the final word; other mid-frame arrivals are
//                dropped and flagged.
//  Revision    : 1.0 - initial release
// ============================================================================
module endec_tx_serializer #(
  parameter int OUT_W = 8
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               en,
  input  logic               i_code_rate,
  input  logic [383:0]       i_encoder_data,
  input  logic               i_encoder_done,
  output logic [OUT_W-1:0]   o_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_last,
  output logic               o_busy,
  output logic               o_overrun
);

  localparam int c_FRAME_W = 384;
  localparam int c_N_R12   = 256 / OUT_W;
  localparam int c_N_R13   = 384 / OUT_W;
  localparam int c_IDX_W   = $clog2(c_N_R13);

  localparam logic [c_IDX_W-1:0] c_LAST_R12 = c_IDX_W'(c_N_R12 - 1);
  localparam logic [c_IDX_W-1:0] c_LAST_R13 = c_IDX_W'(c_N_R13 - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_FRAME_W-1:0] r_frame;
  logic [c_FRAME_W-1:0] w_frame_nxt;
  logic                 r_rate;
  logic                 w_rate_nxt;
  logic [c_IDX_W-1:0]   r_idx;
  logic [c_IDX_W-1:0]   w_idx_nxt;
  logic                 r_overrun;
  logic                 w_overrun_nxt;

  logic                 w_send;
  logic [c_IDX_W-1:0]   w_last_idx;
  logic                 w_at_last;
  logic                 w_xfer;
  logic                 w_load;

  // Handshake and load qualifiers; the frame register is a shift register so
  // the word on offer is always its bottom OUT_W bits.
  assign w_send     = (r_state == ST_SEND);
  assign w_last_idx = r_rate ? c_LAST_R13 : c_LAST_R12;
  assign w_at_last  = w_send && (r_idx == w_last_idx);
  assign w_xfer     = en && w_send && i_ready;
  // A new frame is taken when idle, or on the very transfer that retires the
  // last word of the current frame (seamless back-to-back).
  assign w_load     = en && i_encoder_done && (!w_send || (w_xfer && w_at_last));

  // State, frame, index and overrun flag registers
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_frame   <= '0;
      r_rate    <= 1'b0;
      r_idx     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_frame   <= w_frame_nxt;
      r_rate    <= w_rate_nxt;
      r_idx     <= w_idx_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  // Next-state logic: load takes priority, otherwise advance on a transfer
  always_comb begin
    w_state_nxt   = r_state;
    w_frame_nxt   = r_frame;
    w_rate_nxt    = r_rate;
    w_idx_nxt     = r_idx;
    w_overrun_nxt = 1'b0;

    if (w_load) begin
      w_state_nxt = ST_SEND;
      w_frame_nxt = i_encoder_data;
      w_rate_nxt  = i_code_rate;
      w_idx_nxt   = '0;
    end else if (w_xfer) begin
      if (w_at_last) begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
      end else begin
        w_idx_nxt   = r_idx + c_IDX_W'(1);
        w_frame_nxt = r_frame >> OUT_W;
      end
    end

    // A frame arriving mid-send that was not absorbed as back-to-back is lost
    if (en && i_encoder_done && w_send && !w_load) begin
      w_overrun_nxt = 1'b1;
    end
  end

  // Outputs are pure decodes of registered state, so they cannot move while
  // the handshake stalls or the block is disabled.
  assign o_valid   = w_send;
  assign o_busy    = w_send;
  assign o_last    = w_at_last;
  assign o_data    = w_send ? r_frame[OUT_W-1:0] : '0;
  assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_endec_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_endec_tx_serializer
//  Description : Directed bench for endec_tx_serializer (OUT_W = 8) with a
//                frame-level reference model and a transfer scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_endec_tx_serializer;

  localparam int OUT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b1;
  logic             code_rate = 1'b0;
  logic             done = 1'b0;
  logic             ready = 1'b1;
  logic [383:0]     edata = '0;
  logic [OUT_W-1:0] o_data;
  logic             o_valid;
  logic             o_last;
  logic             o_busy;
  logic             o_overrun;

  endec_tx_serializer #(.OUT_W(OUT_W)) dut (
    .sys_clk        (clk),
    .rst            (rst),
    .en             (en),
    .i_code_rate    (code_rate),
    .i_encoder_data (edata),
    .i_encoder_done (done),
    .o_data         (o_data),
    .o_valid        (o_valid),
    .i_ready        (ready),
    .o_last         (o_last),
    .o_busy         (o_busy),
    .o_overrun      (o_overrun)
  );

  always #5 clk = ~clk;

  int  total = 0;
  int  bad = 0;
  bit  chk_on = 1'b0;

  // Frame-level model: which frame is held, how many words it has, which
  // word is on offer, and whether a drop was just flagged.
  bit           m_busy = 1'b0;
  int           m_k = 0;
  int           m_n = 32;
  bit           m_ovr = 1'b0;
  logic [383:0] m_frame = '0;

  logic [7:0]   obs_q[$];
  logic [7:0]   exp_q[$];
  int           ovr_cnt = 0;
  logic [7:0]   last_word = '0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model update on each rising edge from the inputs in force at that edge
  always @(posedge clk) begin
    bit xfer;
    bit last;
    if (rst) begin
      m_busy = 1'b0;
      m_k    = 0;
      m_n    = 32;
      m_ovr  = 1'b0;
    end else begin
      m_ovr = 1'b0;
      if (en) begin
        xfer = m_busy && ready;
        last = m_busy && (m_k == m_n - 1);
        if (done && (!m_busy || (xfer && last))) begin
          m_frame = edata;
          m_n     = code_rate ? 48 : 32;
          m_k     = 0;
          m_busy  = 1'b1;
        end else begin
          if (done) m_ovr = 1'b1;
          if (xfer) begin
            if (last) begin
              m_busy = 1'b0;
              m_k    = 0;
            end else begin
              m_k++;
            end
          end
        end
      end
    end
  end

  // Per-cycle compare against the model, plus transfer scoreboard capture
  always @(negedge clk) begin
    logic [11:0] exp_v;
    logic [11:0] got_v;
    if (chk_on) begin
      exp_v = {m_busy, m_busy, (m_busy && (m_k == m_n - 1)), m_ovr,
               (m_busy ? m_frame[m_k*OUT_W +: OUT_W] : 8'h00)};
      got_v = {o_valid, o_busy, o_last, o_overrun, o_data};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL cycle {valid,busy,last,ovr,data} got=%03h exp=%03h at %0t",
                 got_v, exp_v, $time);
      end
      if (en && !rst && o_valid && ready) begin
        obs_q.push_back(o_data);
        if (o_last) last_word = o_data;
      end
      if (o_overrun) ovr_cnt++;
    end
  end

  function automatic logic [383:0] mk(input logic [7:0] base);
    logic [383:0] f;
    f = '0;
    for (int k = 0; k < 48; k++) f[k*8 +: 8] = base + 8'(k);
    return f;
  endfunction

  task automatic push_frame(input logic [7:0] base, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(base + 8'(k));
  endtask

  task automatic sb_check(input string nm);
    chk({nm, "_len"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk({nm, "_word"}, 64'(obs_q[i]), 64'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [383:0] d, input logic r);
    edata     = d;
    code_rate = r;
    done      = 1'b1;
    tick();
    done      = 1'b0;
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (o_valid && c < 300) begin
      tick();
      c++;
    end
    chk("idle_reached", 64'(o_valid), 64'd0);
  endtask

  bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_data", 64'(o_data), 64'd0);
    chk("rst_last", 64'(o_last), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_ovr", 64'(o_overrun), 64'd0);
    rst    = 1'b0;
    chk_on = 1'b1;
    tick();

    // Rate 1/2, ready held high
    load(mk(8'h00), 1'b0);
    chk("lat_valid", 64'(o_valid), 64'd1);
    chk("lat_word0", 64'(o_data), 64'h00);
    push_frame(8'h00, 32);
    wait_idle();
    sb_check("r12");
    chk("r12_last_word", 64'(last_word), 64'h1F);
    tick();

    // Rate 1/3; rate input changes after load must not matter
    load(mk(8'h00), 1'b1);
    code_rate = 1'b0;
    push_frame(8'h00, 48);
    wait_idle();
    sb_check("r13");
    chk("r13_last_word", 64'(last_word), 64'h2F);
    tick();

    // Backpressure with ready pattern 1,0,0,1 repeating
    load(mk(8'h00), 1'b0);
    push_frame(8'h00, 32);
    begin
      int c;
      c = 0;
      while (o_valid && c < 400) begin
        ready = pat[c % 4];
        tick();
        c++;
      end
      ready = 1'b1;
    end
    chk("bp_idle", 64'(o_valid), 64'd0);
    sb_check("bp");
    tick();

    // Overrun at word 10, then back-to-back frame on the last transfer
    ovr_cnt = 0;
    load(mk(8'h00), 1'b0);
    repeat (10) tick();
    chk("ovr_at_word10", 64'(o_data), 64'h0A);
    edata = mk(8'h80);
    done  = 1'b1;
    tick();
    done  = 1'b0;
    chk("ovr_pulse", 64'(o_overrun), 64'd1);
    begin
      int c;
      c = 0;
      while (!o_last && c < 100) begin
        tick();
        c++;
      end
    end
    chk("b2b_at_last", 64'(o_data), 64'h1F);
    load(mk(8'h40), 1'b0);
    chk("b2b_valid", 64'(o_valid), 64'd1);
    chk("b2b_word0", 64'(o_data), 64'h40);
    push_frame(8'h00, 32);
    push_frame(8'h40, 32);
    wait_idle();
    sb_check("b2b");
    chk("ovr_count", 64'(ovr_cnt), 64'd1);
    tick();

    // Reset at word 5 of a rate-1/3 frame
    load(mk(8'h10), 1'b1);
    repeat (5) tick();
    chk("rst_mid_word5", 64'(o_data), 64'h15);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_valid", 64'(o_valid), 64'd0);
    repeat (5) tick();
    chk("rst_mid_after", 64'(o_valid), 64'd0);
    push_frame(8'h10, 5);
    sb_check("rst_mid");

    // Enable low for 3 cycles mid-frame, with an ignored done pulse
    ovr_cnt = 0;
    load(mk(8'h20), 1'b0);
    repeat (7) tick();
    en    = 1'b0;
    edata = mk(8'hA0);
    done  = 1'b1;
    repeat (3) tick();
    chk("en0_data", 64'(o_data), 64'h27);
    chk("en0_valid", 64'(o_valid), 64'd1);
    done = 1'b0;
    en   = 1'b1;
    push_frame(8'h20, 32);
    wait_idle();
    sb_check("en0");
    chk("en0_ovr_count", 64'(ovr_cnt), 64'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
